// File: rtl/uart_rx_frame.sv
// ============================================================================
// Module   : uart_rx_frame
// Brief    : Parametrised UART receiver (data width, parity, stop bits, bit
//            period) with valid/ready output, parity/framing errors and
//            overrun detection. Optional macro UART_RX_MAJORITY_EN selects a
//            2-of-3 vote at every sample point.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 1395968,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_overrun,
    output logic                 o_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] C_IDX_LAST  = IW'(DATA_BITS - 1);
    localparam logic          C_STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          C_ODD       = (PARITY == 2);
    localparam logic          C_HAS_PAR   = (PARITY != 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic [IW-1:0]          idx_q;
    logic                   stop_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   perr_q;
    logic                   sync1_q;
    logic                   sync2_q;

    logic                   w_rx_s;
    logic [CW-1:0]          w_samp_last;
    logic                   w_at_sample;
    logic                   w_bit;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= i_rx;
            sync2_q <= sync1_q;
        end
    end

    assign w_rx_s      = sync2_q;
    assign w_samp_last = (state_q == ST_START) ? C_HALF_LAST : C_BIT_LAST;
    assign w_at_sample = (cnt_q == w_samp_last);

`ifdef UART_RX_MAJORITY_EN
    logic vote0_q;
    logic vote1_q;

    // The two cycles ahead of each sample point feed the vote.
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            vote0_q <= 1'b1;
            vote1_q <= 1'b1;
        end else begin
            if (cnt_q == (w_samp_last - CW'(2))) begin
                vote0_q <= w_rx_s;
            end
            if (cnt_q == (w_samp_last - CW'(1))) begin
                vote1_q <= w_rx_s;
            end
        end
    end

    assign w_bit = (vote0_q & vote1_q) | (vote0_q & w_rx_s) | (vote1_q & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            stop_q       <= 1'b0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_parity_err <= 1'b0;
            o_frame_err  <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
            // A delivery later in this block overrides the consume-clear.
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!w_rx_s) begin
                        state_q <= ST_START;
                    end
                end

                ST_START: begin
                    if (w_at_sample) begin
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= w_bit ? ST_IDLE : ST_DATA;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_DATA: begin
                    if (w_at_sample) begin
                        cnt_q   <= '0;
                        shift_q <= {w_bit, shift_q[DATA_BITS-1:1]};
                        if (idx_q == C_IDX_LAST) begin
                            idx_q   <= '0;
                            stop_q  <= 1'b0;
                            perr_q  <= 1'b0;
                            state_q <= C_HAS_PAR ? ST_PARITY : ST_STOP;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_PARITY: begin
                    if (w_at_sample) begin
                        cnt_q   <= '0;
                        perr_q  <= (^shift_q) ^ w_bit ^ C_ODD;
                        stop_q  <= 1'b0;
                        state_q <= ST_STOP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_STOP: begin
                    if (w_at_sample) begin
                        cnt_q <= '0;
                        if (!w_bit) begin
                            o_frame_err <= 1'b1;
                            state_q     <= ST_WAIT_IDLE;
                        end else if (stop_q == C_STOP_LAST) begin
                            state_q <= ST_IDLE;
                            if (!o_valid || i_ready) begin
                                o_data       <= shift_q;
                                o_parity_err <= perr_q;
                                o_valid      <= 1'b1;
                            end else begin
                                o_overrun <= 1'b1;
                            end
                        end else begin
                            stop_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                ST_WAIT_IDLE: begin
                    cnt_q <= '0;
                    if (w_rx_s) begin
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign o_busy = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame.sv
// ============================================================================
// Module   : tb_uart_rx_frame
// Brief    : Directed bench for uart_rx_frame; four receivers (8N1, 8E1, 8O1,
//            7O2) at 16 clocks per bit on a shared clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_frame;

    localparam int C_CPB = 16;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] rx_v;
    logic [3:0] rdy_v;

    wire [7:0] data0;
    wire [7:0] data1;
    wire [7:0] data2;
    wire [6:0] data3;
    wire [3:0] valid_v;
    wire [3:0] perr_v;
    wire [3:0] fe_v;
    wire [3:0] ov_v;
    wire [3:0] busy_v;

    int checks = 0;
    int errors = 0;

    int fe_cnt  [4] = '{default: 0};
    int ov_cnt  [4] = '{default: 0};
    int acc_cnt [4] = '{default: 0};
    int both_cnt    = 0;
    logic [8:0] acc_data [4];
    logic       acc_perr [4];
    logic [8:0] d_ext    [4];

    always #5 clk = ~clk;

    uart_rx_frame #(.CLKS_PER_BIT(C_CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .clk(clk), .i_reset(rst), .i_rx(rx_v[0]), .o_data(data0), .o_valid(valid_v[0]),
        .i_ready(rdy_v[0]), .o_parity_err(perr_v[0]), .o_frame_err(fe_v[0]),
        .o_overrun(ov_v[0]), .o_busy(busy_v[0]));

    uart_rx_frame #(.CLKS_PER_BIT(C_CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut1 (
        .clk(clk), .i_reset(rst), .i_rx(rx_v[1]), .o_data(data1), .o_valid(valid_v[1]),
        .i_ready(rdy_v[1]), .o_parity_err(perr_v[1]), .o_frame_err(fe_v[1]),
        .o_overrun(ov_v[1]), .o_busy(busy_v[1]));

    uart_rx_frame #(.CLKS_PER_BIT(C_CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut2 (
        .clk(clk), .i_reset(rst), .i_rx(rx_v[2]), .o_data(data2), .o_valid(valid_v[2]),
        .i_ready(rdy_v[2]), .o_parity_err(perr_v[2]), .o_frame_err(fe_v[2]),
        .o_overrun(ov_v[2]), .o_busy(busy_v[2]));

    uart_rx_frame #(.CLKS_PER_BIT(C_CPB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut3 (
        .clk(clk), .i_reset(rst), .i_rx(rx_v[3]), .o_data(data3), .o_valid(valid_v[3]),
        .i_ready(rdy_v[3]), .o_parity_err(perr_v[3]), .o_frame_err(fe_v[3]),
        .o_overrun(ov_v[3]), .o_busy(busy_v[3]));

    always_comb begin
        d_ext[0] = {1'b0, data0};
        d_ext[1] = {1'b0, data1};
        d_ext[2] = {1'b0, data2};
        d_ext[3] = {2'b00, data3};
    end

    // Event monitor: inputs change on negedges, so sampling 2 units later sees settled values.
    always @(negedge clk) begin
        #2;
        for (int d = 0; d < 4; d++) begin
            if (fe_v[d]) fe_cnt[d]++;
            if (ov_v[d]) ov_cnt[d]++;
            if (fe_v[d] && ov_v[d]) both_cnt++;
            if (valid_v[d] && rdy_v[d]) begin
                acc_cnt[d]++;
                acc_data[d] = d_ext[d];
                acc_perr[d] = perr_v[d];
            end
        end
    end

    task automatic drive_bit(input int d, input logic b, input int spike);
        for (int j = 0; j < C_CPB; j++) begin
            rx_v[d] = (j == spike) ? ~b : b;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int d, input logic [8:0] data, input int db,
                              input bit par_en, input logic pbit, input int stops,
                              input int spike_bit);
        drive_bit(d, 1'b0, -1);
        for (int i = 0; i < db; i++) drive_bit(d, data[i], (i == spike_bit) ? 8 : -1);
        if (par_en) drive_bit(d, pbit, -1);
        for (int s = 0; s < stops; s++) drive_bit(d, 1'b1, -1);
        rx_v[d] = 1'b1;
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        rx_v  = 4'hF;
        rdy_v = 4'h0;
        repeat (3) @(negedge clk);
        checks++; if (data0 !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data0); end
        checks++; if (valid_v !== 4'h0) begin errors++; $display("FAIL reset_valid: got %h expected 0", valid_v); end
        checks++; if (perr_v !== 4'h0) begin errors++; $display("FAIL reset_perr: got %h expected 0", perr_v); end
        checks++; if (fe_v !== 4'h0) begin errors++; $display("FAIL reset_frame_err: got %h expected 0", fe_v); end
        checks++; if (ov_v !== 4'h0) begin errors++; $display("FAIL reset_overrun: got %h expected 0", ov_v); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy_v !== 4'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_v); end
    endtask

    task automatic test_latency;
        int n = 0;
        logic v = 1'b0;
        logic [7:0] got_d = 8'h00;
        logic got_p = 1'b1;
        rdy_v[0] = 1'b1;
        fork
            send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, -1);
            begin
                @(posedge clk);  // t0: first capture of the start bit
                while (!v && n < 400) begin
                    @(negedge clk);
                    v = valid_v[0];
                    if (v) begin
                        got_d = data0;
                        got_p = perr_v[0];
                    end
                    @(posedge clk);
                    n++;
                end
                @(negedge clk);
                checks++; if (valid_v[0] !== 1'b0) begin errors++; $display("FAIL latency_one_cycle: got %b expected 0", valid_v[0]); end
            end
        join
        checks++; if (n !== 155) begin errors++; $display("FAIL latency_cycles: got %0d expected 155", n); end
        checks++; if (got_d !== 8'hA5) begin errors++; $display("FAIL latency_data: got %h expected a5", got_d); end
        checks++; if (got_p !== 1'b0) begin errors++; $display("FAIL latency_perr: got %b expected 0", got_p); end
    endtask

    task automatic test_parity;
        int a;
        rdy_v[1] = 1'b1;
        rdy_v[2] = 1'b1;
        a = acc_cnt[1];
        send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1, -1);
        repeat (4) @(negedge clk);
        checks++; if (acc_cnt[1] !== a + 1 || acc_data[1] !== 9'h003) begin errors++; $display("FAIL even_bad_data: got %h (n=%0d) expected 003", acc_data[1], acc_cnt[1] - a); end
        checks++; if (acc_perr[1] !== 1'b1) begin errors++; $display("FAIL even_bad_perr: got %b expected 1", acc_perr[1]); end
        a = acc_cnt[1];
        send_frame(1, 9'h003, 8, 1'b1, 1'b0, 1, -1);
        repeat (4) @(negedge clk);
        checks++; if (acc_cnt[1] !== a + 1 || acc_data[1] !== 9'h003) begin errors++; $display("FAIL even_ok_data: got %h (n=%0d) expected 003", acc_data[1], acc_cnt[1] - a); end
        checks++; if (acc_perr[1] !== 1'b0) begin errors++; $display("FAIL even_ok_perr: got %b expected 0", acc_perr[1]); end
        a = acc_cnt[2];
        send_frame(2, 9'h003, 8, 1'b1, 1'b1, 1, -1);
        repeat (4) @(negedge clk);
        checks++; if (acc_cnt[2] !== a + 1 || acc_data[2] !== 9'h003) begin errors++; $display("FAIL odd_ok_data: got %h (n=%0d) expected 003", acc_data[2], acc_cnt[2] - a); end
        checks++; if (acc_perr[2] !== 1'b0) begin errors++; $display("FAIL odd_ok_perr: got %b expected 0", acc_perr[2]); end
    endtask

    task automatic test_back_to_back;
        int a = acc_cnt[0];
        int o = ov_cnt[0];
        rdy_v[0] = 1'b1;
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, -1);
        send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1, -1);
        repeat (4) @(negedge clk);
        checks++; if (acc_cnt[0] - a !== 2) begin errors++; $display("FAIL b2b_count: got %0d expected 2", acc_cnt[0] - a); end
        checks++; if (acc_data[0] !== 9'h0C3) begin errors++; $display("FAIL b2b_data: got %h expected 0c3", acc_data[0]); end
        checks++; if (ov_cnt[0] - o !== 0) begin errors++; $display("FAIL b2b_overrun: got %0d expected 0", ov_cnt[0] - o); end
    endtask

    task automatic test_overrun;
        int a;
        int o = ov_cnt[0];
        rdy_v[0] = 1'b0;
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, -1);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, -1);
        repeat (4) @(negedge clk);
        checks++; if (valid_v[0] !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", valid_v[0]); end
        checks++; if (data0 !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h expected 11", data0); end
        checks++; if (ov_cnt[0] - o !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d expected 1", ov_cnt[0] - o); end
        a = acc_cnt[0];
        rdy_v[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (valid_v[0] !== 1'b0) begin errors++; $display("FAIL ovr_drop: got %b expected 0", valid_v[0]); end
        checks++; if (acc_cnt[0] - a !== 1 || acc_data[0] !== 9'h011) begin errors++; $display("FAIL ovr_consume: got %h (n=%0d) expected 011", acc_data[0], acc_cnt[0] - a); end
    endtask

    task automatic test_break;
        int f = fe_cnt[0];
        int a = acc_cnt[0];
        rdy_v[0] = 1'b1;
        rx_v[0]  = 1'b0;
        repeat (40 * C_CPB) @(negedge clk);
        rx_v[0] = 1'b1;
        repeat (2 * C_CPB) @(negedge clk);
        checks++; if (fe_cnt[0] - f !== 1) begin errors++; $display("FAIL break_frame_err: got %0d expected 1", fe_cnt[0] - f); end
        checks++; if (acc_cnt[0] - a !== 0) begin errors++; $display("FAIL break_no_valid: got %0d expected 0", acc_cnt[0] - a); end
        a = acc_cnt[0];
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, -1);
        repeat (4) @(negedge clk);
        checks++; if (acc_cnt[0] - a !== 1 || acc_data[0] !== 9'h05A) begin errors++; $display("FAIL break_recover: got %h (n=%0d) expected 05a", acc_data[0], acc_cnt[0] - a); end
    endtask

    task automatic test_glitch;
        int f = fe_cnt[0];
        int a = acc_cnt[0];
        int o = ov_cnt[0];
        bit seen = 1'b0;
        rx_v[0] = 1'b0;
        repeat (3) @(negedge clk);
        rx_v[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_v[0]) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL glitch_start: got %b expected 1", seen); end
        checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL glitch_idle: got %b expected 0", busy_v[0]); end
        checks++; if ((fe_cnt[0] - f) + (acc_cnt[0] - a) + (ov_cnt[0] - o) !== 0) begin errors++; $display("FAIL glitch_flags: got %0d expected 0", (fe_cnt[0] - f) + (acc_cnt[0] - a) + (ov_cnt[0] - o)); end
    endtask

`ifdef UART_RX_MAJORITY_EN
    task automatic test_spike;
        int a = acc_cnt[0];
        rdy_v[0] = 1'b1;
        send_frame(0, 9'h0C3, 8, 1'b0, 1'b0, 1, 3);
        repeat (4) @(negedge clk);
        checks++; if (acc_cnt[0] - a !== 1 || acc_data[0] !== 9'h0C3) begin errors++; $display("FAIL spike_data: got %h (n=%0d) expected 0c3", acc_data[0], acc_cnt[0] - a); end
    endtask
`endif

    task automatic test_reset_midframe;
        int a;
        logic [6:0] partial = 7'h55;
        rdy_v[3] = 1'b0;
        send_frame(3, 9'h015, 7, 1'b1, 1'b0, 2, -1);
        repeat (4) @(negedge clk);
        checks++; if (valid_v[3] !== 1'b1 || data3 !== 7'h15) begin errors++; $display("FAIL mid_pre_word: got %h valid %b expected 15 valid 1", data3, valid_v[3]); end
        drive_bit(3, 1'b0, -1);
        for (int i = 0; i < 4; i++) drive_bit(3, partial[i], -1);
        rx_v[3] = partial[4];
        repeat (8) @(negedge clk);
        checks++; if (busy_v[3] !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy_v[3]); end
        rst = 1'b1;
        #1;
        checks++; if (valid_v[3] !== 1'b0 || perr_v[3] !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b/%b expected 0/0", valid_v[3], perr_v[3]); end
        checks++; if (busy_v[3] !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy_v[3]); end
        checks++; if (data3 !== 7'h00) begin errors++; $display("FAIL mid_data: got %h expected 00", data3); end
        rx_v[3] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (busy_v[3] !== 1'b0 || fe_v[3] !== 1'b0) begin errors++; $display("FAIL mid_release: got busy %b fe %b expected 0/0", busy_v[3], fe_v[3]); end
        rdy_v[3] = 1'b1;
        a = acc_cnt[3];
        send_frame(3, 9'h07F, 7, 1'b1, 1'b0, 2, -1);
        repeat (4) @(negedge clk);
        checks++; if (acc_cnt[3] - a !== 1 || acc_data[3] !== 9'h07F) begin errors++; $display("FAIL mid_next_frame: got %h (n=%0d) expected 07f", acc_data[3], acc_cnt[3] - a); end
        checks++; if (acc_perr[3] !== 1'b0) begin errors++; $display("FAIL mid_next_perr: got %b expected 0", acc_perr[3]); end
    endtask

    initial begin
        rst   = 1'b1;
        rx_v  = 4'hF;
        rdy_v = 4'h0;
        @(negedge clk);
        test_reset();
        test_latency();
        test_parity();
        test_back_to_back();
        test_overrun();
        test_break();
        test_glitch();
`ifdef UART_RX_MAJORITY_EN
        test_spike();
`endif
        test_reset_midframe();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL err_overrun_same_cycle: got %0d expected 0", both_cnt); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_frame.md
# uart_rx_frame

Parametrised UART receiver: successor to the fixed 8N1 receiver, generalising data width, parity, stop-bit count and bit period, and adding a valid/ready output handshake, error reporting and overrun detection. Sits between the board RX pin and any byte-consuming logic (FIFO, command parser); one instance per serial channel.

## Interface
- `CLKS_PER_BIT`, default 1395968: clock cycles per bit period; legal range 8 to 2^24.
- `DATA_BITS`, default 8: data bits per frame, 5 to 9.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.
- `clk` input 1: sole clock.
- `i_reset` input 1: asynchronous, active-high reset.
- `i_rx` input 1: serial line, idle high, asynchronous to `clk`.
- `o_data` output DATA_BITS: received word; bit 0 is the first data bit on the line (LSB-first).
- `o_valid` output 1: `o_data` and `o_parity_err` hold a frame.
- `i_ready` input 1: consumer accepts the word when `o_valid && i_ready`.
- `o_parity_err` output 1: parity mismatch on the held word; qualified by `o_valid`.
- `o_frame_err` output 1: one-cycle pulse when a stop bit is sampled low.
- `o_overrun` output 1: one-cycle pulse when a completed frame is dropped.
- `o_busy` output 1: high in any state other than IDLE.

## Operation
- `i_rx` passes through a 2-flop synchroniser, reset to 1; the FSM sees only the synchronised value `rx_s`.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: `rx_s == 0` -> START, bit counter `cnt` = 0.
- START: `cnt` increments; when `cnt == CLKS_PER_BIT/2 - 1`, sample `rx_s`: 0 -> DATA, `cnt` = 0; 1 -> IDLE as a glitch, no flags.
- DATA: sample when `cnt == CLKS_PER_BIT - 1`, then reset `cnt`; store into `o_data`-shadow bit `idx`. After bit `DATA_BITS-1`: PARITY if `PARITY != 0`, else STOP.
- PARITY: one sample; error = XOR(data, parity bit) is 1 for even parity or 0 for odd parity.
- STOP: `STOP_BITS` samples. Any sample 0 -> pulse `o_frame_err`, discard frame, go to WAIT_IDLE. All 1 on the final sample -> deliver, then IDLE.
- WAIT_IDLE: stay until `rx_s == 1`, then IDLE. A line break yields exactly one `o_frame_err`.
- Delivery:
  - If `o_valid == 0`, or `i_ready == 1` in the same cycle: load `o_data`/`o_parity_err` and set `o_valid`.
  - Otherwise keep the old word, drop the new one and pulse `o_overrun`.
- `o_valid` clears on `o_valid && i_ready` unless a delivery occurs in the same cycle.
- A parity-error word is still delivered, with `o_parity_err` = 1.
- Width rules: `cnt` is `$clog2(CLKS_PER_BIT)` bits; `idx` is `$clog2(DATA_BITS)` bits. No counter wraps; every terminal value is compared explicitly.

## Timing
- Reset: state IDLE, `cnt`/`idx` 0, synchroniser 1, `o_data` 0, and all of `o_valid`, `o_parity_err`, `o_frame_err`, `o_overrun`, `o_busy` at 0.
- Reset asserted mid-frame aborts immediately. After release the receiver waits in IDLE for the next falling edge, without flags.
- Let t0 be the edge at which the first synchroniser flop captures the start-bit low.
  - IDLE sees it at t0+2.
  - Start-bit check at t0+2+CLKS_PER_BIT/2.
  - Sample k (k = 1..N, N = DATA_BITS + (PARITY != 0) + STOP_BITS) at that check + k·CLKS_PER_BIT.
- `o_valid` (or `o_frame_err`) is registered at the final-stop sample edge and visible in the following cycle.
- A new start bit is accepted from the cycle after the final-stop sample. Back-to-back frames at full line rate lose nothing if the consumer keeps `i_ready` high.
- `o_frame_err` and `o_overrun` are single-cycle pulses and never assert in the same cycle.

## Configuration
- `UART_RX_MAJORITY_EN` defined: every sample point (start check, data, parity, stop) is the 2-of-3 majority of `rx_s` at `cnt` = sample-2, sample-1, sample. Latency is unchanged. Requires `CLKS_PER_BIT >= 8`.
- Not defined: single sample of `rx_s` at the sample point, with no vote registers.

## Test plan
- CLKS_PER_BIT=16, 8N1, `i_ready`=1, send 0xA5 with falling edge at t0 -> `o_valid` one cycle, `o_data`=0xA5, `o_parity_err`=0, `o_valid` high exactly 155 cycles after t0.
- 8E1, send 0x03 with parity bit 1 -> `o_data`=0x03, `o_parity_err`=1. Repeat with parity 0 -> `o_parity_err`=0. PARITY=2 with 0x03 and parity 1 -> `o_parity_err`=0.
- `i_ready`=0, send 0x11 then 0x22 back-to-back -> `o_data` stays 0x11, one `o_overrun` pulse. Then raise `i_ready` -> 0x11 consumed and `o_valid` drops.
- Hold `i_rx` low for 40 bit times, then release -> exactly one `o_frame_err`, no `o_valid`; a following 0x5A frame is received correctly.
- 3-cycle low glitch on idle line -> no state change beyond START, no flags. With `UART_RX_MAJORITY_EN`, a 1-cycle inverted spike at the centre of a data bit does not corrupt 0xC3.
- Assert `i_reset` during data bit 4 of a frame -> all outputs 0 within that cycle; the next complete 7O2 frame (DATA_BITS=7, PARITY=2, STOP_BITS=2) carrying 0x7F is received correctly.
